input_acc_seq: RTL

INPUT_ACC_SEQ -- requirements
Module: input_acc_seq

---
 rtl/input_acc_seq_pkg.sv | 14 +
 rtl/input_acc_seq_skew_window.sv | 22 ++
 rtl/input_acc_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/input_acc_seq_pkg.sv
// Shared tpu definitions for the input_acc FIFO read sequencer.
// Holds the sequencer FSM encoding and the default array geometry.
package input_acc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  localparam int SA_ROWS_DEF  = 2;
  localparam int MAX_VECS_DEF = 4;

endpackage

// File: rtl/input_acc_seq_skew_window.sv
// One row's read window: high when row ROW's tick falls in
// [ROW, ROW+n), giving the one-cycle-per-row diagonal skew.
module skew_window #(
  parameter int ROW = 0,
  parameter int TW  = 3
) (
  input  logic [TW-1:0] tick,
  input  logic [TW-1:0] n,
  output logic          hit
);

  logic ge;

  if (ROW == 0) begin : g_first
    assign ge = 1'b1;
  end else begin : g_rest
    assign ge = (tick >= TW'(ROW));
  end

  assign hit = ge && (tick < (TW'(ROW) + n));

endmodule

// File: rtl/input_acc_seq.sv
// Sequences skewed dequeue strobes from the per-row input_acc FIFOs
// into the systolic array, one pass of n vectors per start.
module input_acc_seq
  import input_acc_seq_pkg::*;
#(
  parameter  int SA_ROWS  = SA_ROWS_DEF,
  parameter  int MAX_VECS = MAX_VECS_DEF,
  localparam int CNT_W    = $clog2(MAX_VECS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic [CNT_W-1:0]   num_vecs_in,
  input  logic               stall_in,
  input  logic [SA_ROWS-1:0] fifo_nonempty_in,
  output logic [SA_ROWS-1:0] row_rd_en_out,
  output logic [CNT_W-1:0]   vec_idx_out,
  output logic               busy_out,
  output logic               done_out,
  output logic               underflow_out
);

  localparam int TW = $clog2(MAX_VECS + SA_ROWS + 1);

  state_t state, state_d;

  logic [TW-1:0]      t, t_d;
  logic [TW-1:0]      total, win_t, win_n;
  logic [CNT_W-1:0]   n, n_d, n_clamp, idx_d;
  logic [SA_ROWS-1:0] win, rd_d;
  logic               busy_d, done_d, unf_d, issue;

  assign n_clamp = (num_vecs_in > CNT_W'(MAX_VECS)) ?
                   CNT_W'(MAX_VECS) : num_vecs_in;

  // t counts ticks already issued; the start edge issues tick 0
  assign win_t = (state == IDLE) ? '0 : t;
  assign win_n = TW'((state == IDLE) ? n_clamp : n);
  assign total = TW'(n) + TW'(SA_ROWS - 1);

  for (genvar i = 0; i < SA_ROWS; i++) begin : g_row
    skew_window #(
      .ROW (i),
      .TW  (TW)
    ) u_win (
      .tick (win_t),
      .n    (win_n),
      .hit  (win[i])
    );
  end

  always_comb begin
    state_d = state;
    t_d     = t;
    n_d     = n;
    rd_d    = '0;
    idx_d   = vec_idx_out;
    unf_d   = underflow_out;
    issue   = 1'b0;

    unique case (state)
      IDLE: begin
        idx_d = '0;
        if (start_in) begin
          n_d   = n_clamp;
          t_d   = '0;
          unf_d = 1'b0;
          if (n_clamp == '0) begin
            state_d = DONE;
          end else begin
            state_d = STREAM;
            issue   = !stall_in;
          end
        end
      end
      STREAM: begin
        if (t == total) begin
          state_d = DONE;
        end else begin
          issue = !stall_in;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      rd_d  = win;
      t_d   = win_t + TW'(1);
      idx_d = (win_t < win_n) ? CNT_W'(win_t) :
                                CNT_W'(win_n - TW'(1));
      if (|(win & ~fifo_nonempty_in)) begin
        unf_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      t             <= '0;
      n             <= '0;
      row_rd_en_out <= '0;
      vec_idx_out   <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      state         <= state_d;
      t             <= t_d;
      n             <= n_d;
      row_rd_en_out <= rd_d;
      vec_idx_out   <= idx_d;
      busy_out      <= busy_d;
      done_out      <= done_d;
      underflow_out <= unf_d;
    end
  end

endmodule
